// File: rtl/redun_pkg.sv
// Constants and state type shared by the redundant-form normalizer and the squarer datapath.
package redun_pkg;

    localparam int NUM_ELEMENTS  = 33;
    localparam int IN_BIT_LEN    = 17;
    localparam int WORD_LEN      = 16;
    localparam int CARRY_BIT_LEN = IN_BIT_LEN - WORD_LEN + 1;
    localparam int NUM_WORDS     = 2 * NUM_ELEMENTS;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/redun_norm_slice.sv
// Combinational carry ripple across one chunk of redundant coefficients.
module redun_norm_slice
    import redun_pkg::*;
#(
    parameter int WORDS = 6
) (
    input  logic [WORDS-1:0][IN_BIT_LEN-1:0] coef,
    input  logic [CARRY_BIT_LEN-1:0]         carry_in,
    output logic [WORDS-1:0][WORD_LEN-1:0]   digits,
    output logic [CARRY_BIT_LEN-1:0]         carry_out
);

    always_comb begin
        logic [IN_BIT_LEN:0]      sum;
        logic [CARRY_BIT_LEN-1:0] c;
        c      = carry_in;
        sum    = '0;
        digits = '0;
        // The carry into each word is the part of the previous sum above WORD_LEN.
        for (int k = 0; k < WORDS; k++) begin
            sum       = {1'b0, coef[k]} + (IN_BIT_LEN + 1)'(c);
            digits[k] = sum[WORD_LEN-1:0];
            c         = sum[IN_BIT_LEN:WORD_LEN];
        end
        carry_out = c;
    end

endmodule

// File: rtl/redun_normalizer.sv
// Serially resolves inter-word carries of a redundant squarer result into canonical
// WORD_LEN-bit digits, WORDS_PER_CYCLE digits per clock.
module redun_normalizer
    import redun_pkg::*;
#(
    parameter int WORDS_PER_CYCLE = 6
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [NUM_WORDS-1:0][IN_BIT_LEN-1:0] in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [NUM_WORDS-1:0][WORD_LEN-1:0]  out_data,
    output logic [CARRY_BIT_LEN-1:0]            out_carry
);

    localparam int NUM_CHUNKS = NUM_WORDS / WORDS_PER_CYCLE;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    generate
        if (NUM_WORDS % WORDS_PER_CYCLE != 0) begin : g_bad_words_per_cycle
            $error("redun_normalizer: NUM_WORDS must be a multiple of WORDS_PER_CYCLE");
        end
    endgenerate

    state_t                                      state;
    state_t                                      state_next;
    logic [IDX_W-1:0]                            idx;
    logic [NUM_WORDS-1:0][IN_BIT_LEN-1:0]        in_reg;
    logic [CARRY_BIT_LEN-1:0]                    carry_reg;
    logic [WORDS_PER_CYCLE-1:0][WORD_LEN-1:0]    slice_digits;
    logic [CARRY_BIT_LEN-1:0]                    slice_carry;

    // The lowest unprocessed chunk always sits at the bottom of in_reg.
    redun_norm_slice #(
        .WORDS(WORDS_PER_CYCLE)
    ) u_slice (
        .coef     (in_reg[WORDS_PER_CYCLE-1:0]),
        .carry_in (carry_reg),
        .digits   (slice_digits),
        .carry_out(slice_carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)         state_next = RUN;
            RUN:     if (idx == LAST_IDX)  state_next = DONE;
            DONE:    if (out_ready)        state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Input and output registers both shift by one chunk per RUN cycle, so after the
    // last chunk digit 0 has arrived at the bottom of out_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_reg    <= '0;
            carry_reg <= '0;
            idx       <= '0;
            out_data  <= '0;
            out_carry <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_reg    <= in_data;
                        carry_reg <= '0;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    in_reg    <= in_reg >> (WORDS_PER_CYCLE * IN_BIT_LEN);
                    out_data  <= {slice_digits, out_data[NUM_WORDS-1:WORDS_PER_CYCLE]};
                    carry_reg <= slice_carry;
                    idx       <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        out_carry <= slice_carry;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_redun_normalizer.sv
// Bench for redun_normalizer: big-integer reference model, per-cycle output compare, directed and random vectors.
module tb_redun_normalizer;
    import redun_pkg::*;

    localparam int WPC = 6;
    localparam int NW  = NUM_WORDS;
    localparam int LAT = 1 + NW / WPC;
    localparam int BW  = NW * WORD_LEN + WORD_LEN;

    typedef logic [NW-1:0][IN_BIT_LEN-1:0] vec_t;
    typedef logic [NW-1:0][WORD_LEN-1:0]   dig_t;

    logic                     clk;
    logic                     reset;
    logic                     in_valid;
    logic                     in_ready;
    vec_t                     in_data;
    logic                     out_valid;
    logic                     out_ready;
    dig_t                     out_data;
    logic [CARRY_BIT_LEN-1:0] out_carry;

    int checks = 0;
    int errors = 0;

    dig_t                     exp_data;
    logic [CARRY_BIT_LEN-1:0] exp_carry;
    bit                       exp_valid = 0;

    vec_t                     vec;
    dig_t                     pin_d;
    logic [CARRY_BIT_LEN-1:0] pin_c;

    redun_normalizer #(
        .WORDS_PER_CYCLE(WPC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_carry(out_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the canonical digits are the radix-2^WORD_LEN expansion of the weighted sum.
    function automatic void model(input vec_t v, output dig_t d, output logic [CARRY_BIT_LEN-1:0] c);
        logic [BW-1:0] acc;
        logic [BW-1:0] term;
        acc = '0;
        for (int i = 0; i < NW; i++) begin
            term = BW'(v[i]);
            acc  = acc + (term << (WORD_LEN * i));
        end
        d = acc[NW*WORD_LEN-1:0];
        c = acc[NW*WORD_LEN +: CARRY_BIT_LEN];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic sendVector(input vec_t v);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("in_ready_before_send", 32'(in_ready), 32'd1);
        model(v, exp_data, exp_carry);
        exp_valid = 1;
        in_data   = v;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int hold);
        int lat;
        sendVector(v);
        lat = 1;
        while (!out_valid && lat < LAT + 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'(LAT));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("in_ready_in_done", 32'(in_ready), 32'd0);
            checkOutput("out_valid_held", 32'(out_valid), 32'd1);
            in_data  = ~v;
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        exp_valid = 0;
        checkOutput("out_valid_after_handshake", 32'(out_valid), 32'd0);
        checkOutput("in_ready_after_handshake", 32'(in_ready), 32'd1);
    endtask

    // Whenever a result is presented it must equal the model for the vector in flight.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            checks++;
            if (!exp_valid) begin
                errors++;
                $display("[TB] FAIL unexpected_out_valid: got out_valid=1, expected 0");
            end else if (out_data !== exp_data || out_carry !== exp_carry) begin
                int first;
                first = -1;
                for (int i = NW - 1; i >= 0; i--) begin
                    if (out_data[i] !== exp_data[i]) first = i;
                end
                errors++;
                if (first >= 0)
                    $display("[TB] FAIL result_digit[%0d]: got 0x%0h, expected 0x%0h",
                             first, out_data[first], exp_data[first]);
                else
                    $display("[TB] FAIL result_carry: got 0x%0h, expected 0x%0h", out_carry, exp_carry);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;

        // Model pins: a single 0x1FFFF splits into 0xFFFF plus a carried 1.
        vec    = '0;
        vec[0] = IN_BIT_LEN'('h1FFFF);
        model(vec, pin_d, pin_c);
        checkOutput("pin_single_d0", 32'(pin_d[0]), 32'h0000FFFF);
        checkOutput("pin_single_d1", 32'(pin_d[1]), 32'h00000001);
        checkOutput("pin_single_carry", 32'(pin_c), 32'd0);

        // All words 0x1FFFF: word 1 sees 0x20000 and word 2 onward 0x20001, so digits 2.. are 1.
        for (int i = 0; i < NW; i++) vec[i] = IN_BIT_LEN'('h1FFFF);
        model(vec, pin_d, pin_c);
        checkOutput("pin_max_d0", 32'(pin_d[0]), 32'h0000FFFF);
        checkOutput("pin_max_d1", 32'(pin_d[1]), 32'h00000000);
        checkOutput("pin_max_d2", 32'(pin_d[2]), 32'h00000001);
        checkOutput("pin_max_d65", 32'(pin_d[NW-1]), 32'h00000001);
        checkOutput("pin_max_carry", 32'(pin_c), 32'd2);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_carry", 32'(out_carry), 32'd0);
        checkOutput("reset_out_data_zero", 32'(out_data == '0), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        vec = '0;
        applyStimulus(vec, 0);

        vec    = '0;
        vec[0] = IN_BIT_LEN'('h1FFFF);
        applyStimulus(vec, 0);
        checkOutput("single_d1_literal", 32'(out_data[1]), 32'h00000001);

        for (int i = 0; i < NW; i++) vec[i] = IN_BIT_LEN'('h1FFFF);
        applyStimulus(vec, 0);
        checkOutput("max_carry_literal", 32'(out_carry), 32'd2);
        checkOutput("max_d0_literal", 32'(out_data[0]), 32'h0000FFFF);
        checkOutput("max_d6_literal", 32'(out_data[6]), 32'h00000001);

        // Carry landing exactly on a chunk boundary and on the top word.
        vec     = '0;
        vec[5]  = IN_BIT_LEN'('h10000);
        vec[6]  = IN_BIT_LEN'('h0FFFF);
        vec[NW-1] = IN_BIT_LEN'('h1FFFF);
        applyStimulus(vec, 0);
        checkOutput("boundary_d6_literal", 32'(out_data[6]), 32'h00000000);
        checkOutput("boundary_d7_literal", 32'(out_data[7]), 32'h00000001);
        checkOutput("boundary_carry_literal", 32'(out_carry), 32'd1);

        // Result held across a stalled downstream; in_valid in DONE must be dropped.
        for (int i = 0; i < NW; i++) vec[i] = IN_BIT_LEN'($urandom_range(0, (1 << IN_BIT_LEN) - 1));
        applyStimulus(vec, 5);
        repeat (LAT + 3) begin
            @(negedge clk);
            checkOutput("idle_after_ignored_valid", 32'(out_valid), 32'd0);
        end

        // Abort mid-run, then a fresh vector must complete normally.
        for (int i = 0; i < NW; i++) vec[i] = IN_BIT_LEN'('h1FFFF);
        sendVector(vec);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset     = 1'b1;
        exp_valid = 0;
        @(posedge clk);
        #1;
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_out_data_zero", 32'(out_data == '0), 32'd1);
        checkOutput("abort_out_carry", 32'(out_carry), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        vec    = '0;
        vec[3] = IN_BIT_LEN'('h1ABCD);
        vec[4] = IN_BIT_LEN'('h0FFFF);
        applyStimulus(vec, 0);
        checkOutput("after_abort_d3", 32'(out_data[3]), 32'h0000ABCD);
        checkOutput("after_abort_d4", 32'(out_data[4]), 32'h00000000);
        checkOutput("after_abort_d5", 32'(out_data[5]), 32'h00000001);

        for (int r = 0; r < 1000; r++) begin
            for (int i = 0; i < NW; i++) begin
                if (r % 4 == 0) begin
                    case ($urandom_range(0, 3))
                        0:       vec[i] = IN_BIT_LEN'('h1FFFF);
                        1:       vec[i] = IN_BIT_LEN'('h10000);
                        2:       vec[i] = IN_BIT_LEN'('h0FFFF);
                        default: vec[i] = '0;
                    endcase
                end else begin
                    vec[i] = IN_BIT_LEN'($urandom_range(0, (1 << IN_BIT_LEN) - 1));
                end
            end
            applyStimulus(vec, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
